tlul_mem_arbiter: RTL and testbench

- Shares the single TL-UL port of the main-memory SRAM between NumHosts TL-UL requesters, e.g. the multicore system DMA port and a simulation/debug loader.
- Round-robin arbitration on the A channel, with the grant locked while a request is stalled.
- Tracks outstanding requests in an in-order grant FIFO and routes each D-channel response back to the host that issued it.
- Sits between the requesters and the sram device port, in the top level of the system.

---
 rtl/tlul_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_tlul_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_mem_arbiter.sv
// Round-robin arbiter sharing one TL-UL memory port between NumHosts requesters.
// An in-order FIFO of grant indices steers each D-channel beat back to its issuer.
package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_mem_arbiter #(
  parameter int NumHosts       = 2,
  parameter int MaxOutstanding = 4,
  localparam int HostIdxW      = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_h2d_t host_req_i [NumHosts],
  output tlul_pkg::tl_d2h_t host_rsp_o [NumHosts],
  output tlul_pkg::tl_h2d_t dev_req_o,
  input  tlul_pkg::tl_d2h_t dev_rsp_i,
  output logic              busy_o,
  output logic              err_o
);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] Depth = CntW'(MaxOutstanding);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_reg, state_next;
  logic [HostIdxW-1:0]   grant_reg, grant_next;
  logic [HostIdxW-1:0]   rr_reg, rr_next;
  logic [HostIdxW-1:0]   grant, search_idx, cand, head;
  logic                  search_hit, req_present;
  logic [HostIdxW-1:0]   fifo_mem [MaxOutstanding];
  logic [PtrW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0]       count_reg;
  logic                  err_reg;
  logic                  full, empty, push, pop;
  logic                  a_valid_dev, d_ready_dev;

  function automatic logic [HostIdxW-1:0] next_host(input logic [HostIdxW-1:0] h);
    if (int'(h) == NumHosts - 1) return '0;
    return h + 1'b1;
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    if (int'(p) == MaxOutstanding - 1) return '0;
    return p + 1'b1;
  endfunction

  assign full  = (count_reg == Depth);
  assign empty = (count_reg == '0);
  assign head  = fifo_mem[rd_ptr_reg];

  // Descending scan so the smallest offset from the RR pointer wins.
  always_comb begin
    search_hit = 1'b0;
    search_idx = '0;
    cand       = '0;
    for (int off = NumHosts - 1; off >= 0; off--) begin
      cand = HostIdxW'((int'(rr_reg) + off) % NumHosts);
      if (host_req_i[cand].a_valid) begin
        search_hit = 1'b1;
        search_idx = cand;
      end
    end
  end

  assign grant       = (state_reg == LOCKED) ? grant_reg : search_idx;
  assign req_present = (state_reg == LOCKED) ? host_req_i[grant_reg].a_valid : search_hit;
  // Full is judged on the registered count only; a same-cycle pop does not free a slot.
  assign a_valid_dev = req_present && !full && !rst_i;
  assign push        = a_valid_dev && dev_rsp_i.a_ready;
  // With nothing outstanding, stray beats are sunk so the device never stalls on them.
  assign d_ready_dev = !rst_i && (empty || host_req_i[head].d_ready);
  assign pop         = dev_rsp_i.d_valid && d_ready_dev && !empty;

  always_comb begin
    dev_req_o         = host_req_i[grant];
    dev_req_o.a_valid = a_valid_dev;
    dev_req_o.d_ready = d_ready_dev;
  end

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      host_rsp_o[i] = '0;
      if (!rst_i && !empty && int'(head) == i) begin
        host_rsp_o[i] = dev_rsp_i;
      end
      host_rsp_o[i].a_ready = a_valid_dev && (int'(grant) == i) && dev_rsp_i.a_ready;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_next    = rr_reg;
    case (state_reg)
      IDLE: begin
        if (push) begin
          rr_next = next_host(grant);
        end else if (a_valid_dev) begin
          grant_next = grant;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (push) begin
          rr_next    = next_host(grant_reg);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_reg     <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
      if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (dev_rsp_i.d_valid && d_ready_dev && empty) err_reg <= 1'b1;
    end
  end

  // Index storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= grant;
  end

  assign busy_o = !empty || (state_reg == LOCKED);
  assign err_o  = err_reg;
endmodule

// File: tb/tb_tlul_mem_arbiter.sv
// Directed bench for tlul_mem_arbiter: two hosts, depth-4 grant FIFO, device driven by hand.
module tb_tlul_mem_arbiter;
  import tlul_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  tl_h2d_t host_req [2];
  tl_d2h_t host_rsp [2];
  tl_h2d_t dev_req;
  tl_d2h_t dev_rsp;
  logic    busy, err;
  int      n_assert = 0;
  int      n_fail   = 0;

  tlul_mem_arbiter #(.NumHosts(2), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_i(rst), .host_req_i(host_req), .host_rsp_o(host_rsp),
    .dev_req_o(dev_req), .dev_rsp_i(dev_rsp), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int h, input logic v, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] data);
    host_req[h].a_valid   = v;
    host_req[h].a_opcode  = op;
    host_req[h].a_address = addr;
    host_req[h].a_data    = data;
    host_req[h].a_mask    = 4'hf;
    host_req[h].a_size    = 2'd2;
    host_req[h].a_source  = 8'(h);
  endtask

  task automatic set_d(input logic v, input logic [2:0] op, input logic [31:0] data);
    dev_rsp.d_valid  = v;
    dev_rsp.d_opcode = op;
    dev_rsp.d_data   = data;
  endtask

  initial begin
    host_req[0] = '0;
    host_req[1] = '0;
    dev_rsp     = '0;
    host_req[0].d_ready = 1'b1;
    host_req[1].d_ready = 1'b1;

    // Reset: outputs held idle even with a requester and a ready device.
    set_a(0, 1'b1, Get, 32'h0, 32'h0);
    dev_rsp.a_ready = 1'b1;
    #2;
    $display("step: reset state");
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_a_ready0", 64'(host_rsp[0].a_ready), 64'd0);
    chk("rst_dev_a_valid", 64'(dev_req.a_valid), 64'd0);
    chk("rst_dev_d_ready", 64'(dev_req.d_ready), 64'd0);
    chk("rst_d_valid0", 64'(host_rsp[0].d_valid), 64'd0);
    set_a(0, 1'b0, Get, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Two hosts compete, device always ready.
    $display("step: two-host round robin");
    set_a(0, 1'b1, Get, 32'h0, 32'h0);
    set_a(1, 1'b1, Get, 32'h100, 32'h0);
    #1;
    chk("rr1_addr", 64'(dev_req.a_address), 64'h0);
    chk("rr1_a_ready0", 64'(host_rsp[0].a_ready), 64'd1);
    chk("rr1_a_ready1", 64'(host_rsp[1].a_ready), 64'd0);
    tick();
    set_a(0, 1'b0, Get, 32'h0, 32'h0);
    #1;
    chk("rr2_addr", 64'(dev_req.a_address), 64'h100);
    chk("rr2_a_ready1", 64'(host_rsp[1].a_ready), 64'd1);
    tick();
    set_a(1, 1'b0, Get, 32'h0, 32'h0);
    set_d(1'b1, AccessAckData, 32'haaaa);
    #1;
    chk("rsp1_d_valid0", 64'(host_rsp[0].d_valid), 64'd1);
    chk("rsp1_data0", 64'(host_rsp[0].d_data), 64'haaaa);
    chk("rsp1_d_valid1", 64'(host_rsp[1].d_valid), 64'd0);
    chk("rsp1_busy", 64'(busy), 64'd1);
    tick();
    set_d(1'b1, AccessAckData, 32'hbbbb);
    #1;
    chk("rsp2_d_valid1", 64'(host_rsp[1].d_valid), 64'd1);
    chk("rsp2_data1", 64'(host_rsp[1].d_data), 64'hbbbb);
    chk("rsp2_d_valid0", 64'(host_rsp[0].d_valid), 64'd0);
    tick();
    set_d(1'b0, AccessAck, 32'h0);
    #1;
    chk("rr_idle_busy", 64'(busy), 64'd0);
    chk("rr_idle_err", 64'(err), 64'd0);
    // RR pointer back at 0: host0 wins a fresh tie (probe only, no edge taken).
    set_a(0, 1'b1, Get, 32'h0, 32'h0);
    set_a(1, 1'b1, Get, 32'h100, 32'h0);
    #1;
    chk("rr_ptr_zero", 64'(dev_req.a_address), 64'h0);
    set_a(0, 1'b0, Get, 32'h0, 32'h0);
    set_a(1, 1'b0, Get, 32'h0, 32'h0);
    tick();

    // Stall on host1, host0 arrives during the stall.
    $display("step: locked grant during stall");
    dev_rsp.a_ready = 1'b0;
    set_a(1, 1'b1, PutFullData, 32'h200, 32'h1234);
    #1;
    chk("lk1_dev_a_valid", 64'(dev_req.a_valid), 64'd1);
    chk("lk1_addr", 64'(dev_req.a_address), 64'h200);
    chk("lk1_a_ready1", 64'(host_rsp[1].a_ready), 64'd0);
    tick();
    set_a(0, 1'b1, Get, 32'h300, 32'h0);
    #1;
    chk("lk2_addr", 64'(dev_req.a_address), 64'h200);
    chk("lk2_opcode", 64'(dev_req.a_opcode), 64'(PutFullData));
    chk("lk2_busy", 64'(busy), 64'd1);
    tick();
    #1;
    chk("lk3_addr", 64'(dev_req.a_address), 64'h200);
    chk("lk3_data", 64'(dev_req.a_data), 64'h1234);
    chk("lk3_a_ready0", 64'(host_rsp[0].a_ready), 64'd0);
    tick();
    dev_rsp.a_ready = 1'b1;
    #1;
    chk("lk4_addr", 64'(dev_req.a_address), 64'h200);
    chk("lk4_a_ready1", 64'(host_rsp[1].a_ready), 64'd1);
    chk("lk4_a_ready0", 64'(host_rsp[0].a_ready), 64'd0);
    tick();
    set_a(1, 1'b0, Get, 32'h0, 32'h0);
    #1;
    chk("lk5_addr", 64'(dev_req.a_address), 64'h300);
    chk("lk5_a_ready0", 64'(host_rsp[0].a_ready), 64'd1);
    tick();
    set_a(0, 1'b0, Get, 32'h0, 32'h0);

    // Responses: host1 first, then host0 stalls d_ready for two cycles.
    $display("step: d_ready backpressure");
    set_d(1'b1, AccessAck, 32'h0);
    #1;
    chk("bp0_d_valid1", 64'(host_rsp[1].d_valid), 64'd1);
    tick();
    host_req[0].d_ready = 1'b0;
    set_d(1'b1, AccessAckData, 32'hc0de);
    #1;
    chk("bp1_dev_d_ready", 64'(dev_req.d_ready), 64'd0);
    chk("bp1_d_valid0", 64'(host_rsp[0].d_valid), 64'd1);
    chk("bp1_d_valid1", 64'(host_rsp[1].d_valid), 64'd0);
    tick();
    #1;
    chk("bp2_dev_d_ready", 64'(dev_req.d_ready), 64'd0);
    chk("bp2_d_valid1", 64'(host_rsp[1].d_valid), 64'd0);
    chk("bp2_busy", 64'(busy), 64'd1);
    tick();
    host_req[0].d_ready = 1'b1;
    #1;
    chk("bp3_dev_d_ready", 64'(dev_req.d_ready), 64'd1);
    chk("bp3_data0", 64'(host_rsp[0].d_data), 64'hc0de);
    tick();
    set_d(1'b0, AccessAck, 32'h0);
    #1;
    chk("bp_done_busy", 64'(busy), 64'd0);
    chk("bp_done_err", 64'(err), 64'd0);

    // Fill the FIFO from a single host with the device withholding responses.
    $display("step: fifo full");
    for (int k = 0; k < 4; k++) begin
      set_a(0, 1'b1, PutFullData, 32'h1000 + 32'(k * 4), 32'(k));
      #1;
      chk($sformatf("fill%0d_a_ready", k), 64'(host_rsp[0].a_ready), 64'd1);
      tick();
    end
    set_a(0, 1'b1, PutFullData, 32'h1010, 32'h4);
    #1;
    chk("full_a_ready", 64'(host_rsp[0].a_ready), 64'd0);
    chk("full_dev_a_valid", 64'(dev_req.a_valid), 64'd0);
    tick();
    set_d(1'b1, AccessAck, 32'h0);
    #1;
    chk("full_pop_a_ready", 64'(host_rsp[0].a_ready), 64'd0);
    chk("full_pop_d_valid0", 64'(host_rsp[0].d_valid), 64'd1);
    tick();
    set_d(1'b0, AccessAck, 32'h0);
    #1;
    chk("after_pop_a_ready", 64'(host_rsp[0].a_ready), 64'd1);
    chk("after_pop_addr", 64'(dev_req.a_address), 64'h1010);
    tick();
    set_a(0, 1'b0, Get, 32'h0, 32'h0);
    #1;
    chk("refull_busy", 64'(busy), 64'd1);
    set_d(1'b1, AccessAck, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    set_d(1'b0, AccessAck, 32'h0);
    #1;
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_err", 64'(err), 64'd0);

    // Stray beat with nothing outstanding.
    $display("step: stray response");
    set_d(1'b1, AccessAckData, 32'hdead);
    #1;
    chk("stray_dev_d_ready", 64'(dev_req.d_ready), 64'd1);
    chk("stray_d_valid0", 64'(host_rsp[0].d_valid), 64'd0);
    chk("stray_d_valid1", 64'(host_rsp[1].d_valid), 64'd0);
    chk("stray_err_before", 64'(err), 64'd0);
    tick();
    set_d(1'b0, AccessAck, 32'h0);
    #1;
    chk("stray_err_set", 64'(err), 64'd1);
    tick();
    tick();
    chk("stray_err_sticky", 64'(err), 64'd1);

    // Reset with three outstanding and host1 locked.
    $display("step: reset mid-operation");
    for (int k = 0; k < 3; k++) begin
      set_a(0, 1'b1, Get, 32'h2000 + 32'(k * 4), 32'h0);
      tick();
    end
    set_a(0, 1'b0, Get, 32'h0, 32'h0);
    dev_rsp.a_ready = 1'b0;
    set_a(1, 1'b1, Get, 32'h400, 32'h0);
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    dev_rsp.a_ready = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_a_ready1", 64'(host_rsp[1].a_ready), 64'd0);
    chk("mid_rst_dev_a_valid", 64'(dev_req.a_valid), 64'd0);
    tick();
    chk("rst_edge_busy", 64'(busy), 64'd0);
    chk("rst_edge_d_valid0", 64'(host_rsp[0].d_valid), 64'd0);
    rst = 1'b0;
    set_a(1, 1'b0, Get, 32'h0, 32'h0);
    set_a(0, 1'b1, Get, 32'h500, 32'h0);
    #1;
    chk("post_rst_addr", 64'(dev_req.a_address), 64'h500);
    chk("post_rst_a_ready0", 64'(host_rsp[0].a_ready), 64'd1);
    tick();
    set_a(0, 1'b0, Get, 32'h0, 32'h0);
    set_d(1'b1, AccessAckData, 32'h55);
    #1;
    chk("post_rst_d_valid0", 64'(host_rsp[0].d_valid), 64'd1);
    chk("post_rst_data0", 64'(host_rsp[0].d_data), 64'h55);
    tick();
    set_d(1'b0, AccessAck, 32'h0);
    #1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_err", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
